axi4_burst_sram_slave: RTL and testbench

Parametrised AXI4 slave memory model with a UART transmit hook, used as the simulation main memory behind the CPU's AXI4 master.
Read and write channels have independent state machines, so a read and a write can be in flight at the same time.
- Supports INCR and FIXED bursts up to 256 beats.
- Read latency is configurable.
- Returns DECERR and SLVERR responses.
- UART output is a registered byte strobe rather than a simulator print.

---
 rtl/axi4_burst_sram_slave.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_axi4_burst_sram_slave.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_sram_slave.sv
// AXI4 burst SRAM slave used as simulation main memory, with a UART TX byte strobe.
// Independent read and write FSMs; INCR/FIXED bursts, configurable read latency.
module axi4_burst_sram_slave #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       ID_W      = 4,
    parameter int unsigned       MEM_AW    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] UART_ADDR = 32'hA000_03F8,
    parameter int unsigned       RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,

    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,

    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,

    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,

    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,

    output logic                uart_tx_valid,
    output logic [7:0]          uart_tx_data
);

    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned BYTE_AW = $clog2(STRB_W);
    localparam int unsigned IDX_W   = MEM_AW - BYTE_AW;
    localparam int unsigned DEPTH   = 1 << IDX_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [3:0] LAT_LOAD    = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [DATA_W-1:0] mem_q [DEPTH];

    function automatic logic in_mem(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (off >> MEM_AW) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] mem_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> BYTE_AW);
    endfunction

    // WRAP and reserved bursts, or transfers wider than the bus, are slave errors
    function automatic logic cfg_err(input logic [2:0] sz, input logic [1:0] bu);
        return bu[1] || (32'(sz) > BYTE_AW);
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] sz,
                                                    input logic [1:0] bu);
        return (bu == BURST_FIXED) ? a : a + (ADDR_W'(1) << sz);
    endfunction

    // ---------------- read channel ----------------
    r_state_e          r_state_q;
    logic              arready_q, rvalid_q, rlast_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [7:0]        rlen_q, rbeat_q;
    logic [2:0]        rsize_q;
    logic [1:0]        rburst_q;
    logic [3:0]        lat_q;

    logic              ar_hs_c, r_hs_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [2:0]        rd_size_c;
    logic [1:0]        rd_burst_c, rd_resp_c;
    logic [DATA_W-1:0] rd_data_c;

    // Beat data is fetched when the beat is prepared: at AR handshake for the
    // first beat, so a write landing during the latency window is not seen.
    always_comb begin
        ar_hs_c    = arvalid && arready_q;
        r_hs_c     = rvalid_q && rready;
        rd_addr_c  = next_addr(raddr_q, rsize_q, rburst_q);
        rd_size_c  = rsize_q;
        rd_burst_c = rburst_q;
        if (r_state_q == R_IDLE) begin
            rd_addr_c  = araddr;
            rd_size_c  = arsize;
            rd_burst_c = arburst;
        end
        rd_resp_c = RESP_OKAY;
        if (!in_mem(rd_addr_c)) begin
            rd_resp_c = RESP_DECERR;
        end else if (cfg_err(rd_size_c, rd_burst_c)) begin
            rd_resp_c = RESP_SLVERR;
        end
        rd_data_c = (rd_resp_c == RESP_OKAY) ? mem_q[mem_idx(rd_addr_c)] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            lat_q     <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs_c) begin
                        arready_q <= 1'b0;
                        rid_q     <= arid;
                        raddr_q   <= araddr;
                        rlen_q    <= arlen;
                        rsize_q   <= arsize;
                        rburst_q  <= arburst;
                        rbeat_q   <= '0;
                        rdata_q   <= rd_data_c;
                        rresp_q   <= rd_resp_c;
                        rlast_q   <= (arlen == 8'd0);
                        lat_q     <= LAT_LOAD;
                        if (RD_LAT <= 1) begin
                            rvalid_q  <= 1'b1;
                            r_state_q <= R_BEAT;
                        end else begin
                            r_state_q <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (lat_q <= 4'd1) begin
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_BEAT;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                R_BEAT: begin
                    if (r_hs_c) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            raddr_q <= rd_addr_c;
                            rbeat_q <= rbeat_q + 8'd1;
                            rdata_q <= rd_data_c;
                            rresp_q <= rd_resp_c;
                            rlast_q <= ((rbeat_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // ---------------- write channel ----------------
    w_state_e          w_state_q;
    logic              awready_q, wready_q, bvalid_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q, wresp_acc_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        wlen_q, wbeat_q;
    logic [2:0]        wsize_q;
    logic [1:0]        wburst_q;
    logic              uart_valid_q;
    logic [7:0]        uart_data_q;

    logic              aw_hs_c, w_hs_c, w_uart_c, w_last_beat_c, w_cfg_err_c, w_in_mem_c;
    logic              mem_we_c, uart_fire_c;
    logic [1:0]        w_beat_resp_c, w_resp_acc_c;
    logic [IDX_W-1:0]  mem_widx_c;

    always_comb begin
        aw_hs_c       = awvalid && awready_q;
        w_hs_c        = wvalid && wready_q;
        w_uart_c      = (waddr_q == UART_ADDR);
        w_last_beat_c = (wbeat_q == wlen_q);
        w_cfg_err_c   = cfg_err(wsize_q, wburst_q);
        w_in_mem_c    = in_mem(waddr_q);
        w_beat_resp_c = RESP_OKAY;
        if (!w_in_mem_c && !w_uart_c) begin
            w_beat_resp_c = RESP_DECERR;
        end else if (w_cfg_err_c || (wlast != w_last_beat_c)) begin
            w_beat_resp_c = RESP_SLVERR;
        end
        // OKAY < SLVERR < DECERR numerically, so worst-of is a max
        w_resp_acc_c = (w_beat_resp_c > wresp_acc_q) ? w_beat_resp_c : wresp_acc_q;
        mem_we_c     = w_hs_c && w_in_mem_c && !w_cfg_err_c && !rst;
        mem_widx_c   = mem_idx(waddr_q);
        uart_fire_c  = w_hs_c && w_uart_c && wstrb[0];
    end

    // Memory array has no reset so its contents survive rst
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_q[mem_widx_c][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q    <= W_IDLE;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bid_q        <= '0;
            bresp_q      <= RESP_OKAY;
            wresp_acc_q  <= RESP_OKAY;
            waddr_q      <= '0;
            wlen_q       <= '0;
            wbeat_q      <= '0;
            wsize_q      <= '0;
            wburst_q     <= '0;
            uart_valid_q <= 1'b0;
            uart_data_q  <= '0;
        end else begin
            uart_valid_q <= uart_fire_c;
            if (uart_fire_c) begin
                uart_data_q <= wdata[7:0];
            end
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_hs_c) begin
                        awready_q   <= 1'b0;
                        wready_q    <= 1'b1;
                        bid_q       <= awid;
                        waddr_q     <= awaddr;
                        wlen_q      <= awlen;
                        wsize_q     <= awsize;
                        wburst_q    <= awburst;
                        wbeat_q     <= '0;
                        wresp_acc_q <= RESP_OKAY;
                        w_state_q   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_c) begin
                        if (w_last_beat_c) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= w_resp_acc_c;
                            w_state_q <= W_RESP;
                        end else begin
                            waddr_q     <= next_addr(waddr_q, wsize_q, wburst_q);
                            wbeat_q     <= wbeat_q + 8'd1;
                            wresp_acc_q <= w_resp_acc_c;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid_q && bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign arready       = arready_q;
    assign rid           = rid_q;
    assign rdata         = rdata_q;
    assign rresp         = rresp_q;
    assign rlast         = rlast_q;
    assign rvalid        = rvalid_q;
    assign awready       = awready_q;
    assign wready        = wready_q;
    assign bid           = bid_q;
    assign bresp         = bresp_q;
    assign bvalid        = bvalid_q;
    assign uart_tx_valid = uart_valid_q;
    assign uart_tx_data  = uart_data_q;

endmodule

// File: tb/tb_axi4_burst_sram_slave.sv
// Directed self-checking bench for axi4_burst_sram_slave (RD_LAT=3, 32-bit data).
module tb_axi4_burst_sram_slave;

    logic        clk, rst;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen, uart_tx_data;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready, uart_tx_valid;
    logic [3:0]  wstrb;

    int errors = 0;
    int checks = 0;

    axi4_burst_sram_slave #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .MEM_AW(16),
                            .BASE_ADDR(32'h8000_0000), .UART_ADDR(32'hA000_03F8),
                            .RD_LAT(3)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        for (int n = 0; n < 40 && !arready; n++) tick();
        chk("ar_ready", arready, 1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic rd_beat(output logic [31:0] d, output logic [1:0] rs,
                           output logic l, output logic [3:0] id);
        for (int n = 0; n < 40 && !rvalid; n++) tick();
        chk("r_valid", rvalid, 1);
        d = rdata; rs = rresp; l = rlast; id = rid;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        for (int n = 0; n < 40 && !awready; n++) tick();
        chk("aw_ready", awready, 1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        for (int n = 0; n < 40 && !wready; n++) tick();
        chk("w_ready", wready, 1);
        tick();
        wvalid = 1'b0;
    endtask

    task automatic b_recv(output logic [1:0] rs, output logic [3:0] id);
        bready = 1'b1;
        for (int n = 0; n < 40 && !bvalid; n++) tick();
        chk("b_valid", bvalid, 1);
        rs = bresp; id = bid;
        tick();
        bready = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] d);
        logic [1:0] rs;
        logic [3:0] id;
        aw_send(4'd0, addr, 8'd0, 2'b01);
        w_beat(d, 4'hF, 1'b1);
        b_recv(rs, id);
        chk("ww_bresp", rs, 2'b00);
    endtask

    task automatic read_word(input logic [31:0] addr, output logic [31:0] d, output logic l);
        logic [1:0] rs;
        logic [3:0] id;
        ar_send(4'd0, addr, 8'd0, 2'b01);
        rd_beat(d, rs, l, id);
        chk("rw_rresp", rs, 2'b00);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [31:0] d;
        logic [1:0]  rs;
        logic        l;
        logic [3:0]  id;
        logic [5:0]  pat;
        logic [31:0] exp_rb [4];
        int          b;

        rst = 1'b1;
        arvalid = 0; awvalid = 0; wvalid = 0; rready = 0; bready = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wdata = 0; wstrb = 0; wlast = 0;
        repeat (3) tick();

        // reset state
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_uart_valid", uart_tx_valid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bresp", bresp, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_arready", arready, 1);
        chk("post_rst_awready", awready, 1);

        // preload and single read with latency 3
        write_word(32'h8000_0010, 32'hDEAD_BEEF);
        ar_send(4'd5, 32'h8000_0010, 8'd0, 2'b01);
        chk("lat_c1_rvalid", rvalid, 0);
        tick();
        chk("lat_c2_rvalid", rvalid, 0);
        tick();
        chk("lat_c3_rvalid", rvalid, 1);
        chk("single_rdata", rdata, 32'hDEAD_BEEF);
        chk("single_rresp", rresp, 2'b00);
        chk("single_rlast", rlast, 1);
        chk("single_rid", rid, 4'd5);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("single_done_rvalid", rvalid, 0);
        chk("single_done_arready", arready, 1);

        // INCR write of 4 beats, beat 2 with partial strobe
        write_word(32'h8000_0108, 32'hCAFE_F00D);
        aw_send(4'd9, 32'h8000_0100, 8'd3, 2'b01);
        w_beat(32'h1111_1111, 4'hF, 1'b0);
        w_beat(32'h2222_2222, 4'hF, 1'b0);
        w_beat(32'h3333_3333, 4'h3, 1'b0);
        w_beat(32'h4444_4444, 4'hF, 1'b1);
        b_recv(rs, id);
        chk("incr_bresp", rs, 2'b00);
        chk("incr_bid", id, 4'd9);

        // readback with rready pattern 1,0,1,1,0,1
        exp_rb[0] = 32'h1111_1111;
        exp_rb[1] = 32'h2222_2222;
        exp_rb[2] = 32'hCAFE_3333;
        exp_rb[3] = 32'h4444_4444;
        pat = 6'b101101;
        b = 0;
        ar_send(4'd3, 32'h8000_0100, 8'd3, 2'b01);
        for (int n = 0; n < 40 && !rvalid; n++) tick();
        chk("rb_first_valid", rvalid, 1);
        for (int k = 0; k < 6; k++) begin
            rready = pat[k];
            chk("rb_rvalid", rvalid, 1);
            chk("rb_rdata", rdata, exp_rb[b]);
            chk("rb_rlast", rlast, (b == 3));
            chk("rb_rid", rid, 4'd3);
            if (pat[k]) b++;
            tick();
        end
        rready = 1'b0;
        chk("rb_done_rvalid", rvalid, 0);

        // UART byte
        aw_send(4'd1, 32'hA000_03F8, 8'd0, 2'b01);
        w_beat(32'h0000_0041, 4'h1, 1'b1);
        chk("uart_valid_hi", uart_tx_valid, 1);
        chk("uart_data", uart_tx_data, 8'h41);
        b_recv(rs, id);
        chk("uart_valid_lo", uart_tx_valid, 0);
        chk("uart_bresp", rs, 2'b00);
        read_word(32'h8000_0010, d, l);
        chk("uart_mem_intact", d, 32'hDEAD_BEEF);

        // DECERR read, 2 beats
        ar_send(4'd6, 32'h0000_1000, 8'd1, 2'b01);
        rd_beat(d, rs, l, id);
        chk("dec_b0_resp", rs, 2'b11);
        chk("dec_b0_data", d, 0);
        chk("dec_b0_last", l, 0);
        rd_beat(d, rs, l, id);
        chk("dec_b1_resp", rs, 2'b11);
        chk("dec_b1_data", d, 0);
        chk("dec_b1_last", l, 1);

        // WRAP burst read is SLVERR
        ar_send(4'd7, 32'h8000_0010, 8'd0, 2'b10);
        rd_beat(d, rs, l, id);
        chk("wrap_resp", rs, 2'b10);
        chk("wrap_data", d, 0);
        chk("wrap_id", id, 4'd7);

        // DECERR write
        aw_send(4'd2, 32'h0000_1000, 8'd0, 2'b01);
        w_beat(32'h1234_5678, 4'hF, 1'b1);
        b_recv(rs, id);
        chk("dec_wr_bresp", rs, 2'b11);

        // early wlast: SLVERR, but both beats still written
        aw_send(4'd4, 32'h8000_0200, 8'd1, 2'b01);
        w_beat(32'hAAAA_5555, 4'hF, 1'b1);
        w_beat(32'h5A5A_5A5A, 4'hF, 1'b1);
        b_recv(rs, id);
        chk("early_wlast_bresp", rs, 2'b10);
        chk("early_wlast_bid", id, 4'd4);
        read_word(32'h8000_0200, d, l);
        chk("early_wlast_b0", d, 32'hAAAA_5555);
        read_word(32'h8000_0204, d, l);
        chk("early_wlast_b1", d, 32'h5A5A_5A5A);

        // simultaneous AR and AW to one word
        write_word(32'h8000_0300, 32'h0000_0001);
        arid = 4'd2; araddr = 32'h8000_0300; arlen = 0; arsize = 3'd2; arburst = 2'b01;
        awid = 4'd3; awaddr = 32'h8000_0300; awlen = 0; awsize = 3'd2; awburst = 2'b01;
        wdata = 32'h0000_0002; wstrb = 4'hF; wlast = 1'b1;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        chk("sim_arready", arready, 1);
        chk("sim_awready", awready, 1);
        tick();
        arvalid = 1'b0; awvalid = 1'b0;
        chk("sim_ar_taken", arready, 0);
        chk("sim_aw_taken", awready, 0);
        chk("sim_wready", wready, 1);
        tick();
        wvalid = 1'b0;
        b_recv(rs, id);
        chk("sim_bresp", rs, 2'b00);
        chk("sim_bid", id, 4'd3);
        rd_beat(d, rs, l, id);
        chk("sim_old_data", d, 32'h0000_0001);
        chk("sim_rid", id, 4'd2);
        read_word(32'h8000_0300, d, l);
        chk("sim_new_data", d, 32'h0000_0002);

        // reset in the middle of an 8-beat read
        ar_send(4'd1, 32'h8000_0100, 8'd7, 2'b01);
        for (int n = 0; n < 40 && !rvalid; n++) tick();
        chk("mid_b0_data", rdata, 32'h1111_1111);
        rready = 1'b1;
        tick();
        chk("mid_b1_data", rdata, 32'h2222_2222);
        rst = 1'b1;
        rready = 1'b0;
        tick();
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_arready", arready, 0);
        rst = 1'b0;
        tick();
        chk("mid_after_arready", arready, 1);
        chk("mid_after_rvalid", rvalid, 0);
        read_word(32'h8000_0010, d, l);
        chk("mid_new_read", d, 32'hDEAD_BEEF);
        chk("mid_new_rlast", l, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
